// File: rtl/mul_sched.sv
// mul_sched: two-requester round-robin front end to a 4x4 unsigned shift-add
// multiplier that produces one 8-bit product per operation over four cycles.
`default_nettype none

module mul_sched #(
  parameter int RR_INIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       res_valid,
  output logic [7:0] res_data,
  output logic       res_id,
  input  logic       res_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_served;
  logic        grant;
  logic        accept;
  logic [3:0]  a_q;
  logic [8:0]  p_q;
  logic [1:0]  cnt;
  logic        id_q;
  logic [7:0]  res_data_q;
  logic        res_id_q;
  logic [4:0]  sum;
  logic [8:0]  p_step;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // On contention the requester that was not served last goes first.
        if (req0_valid && req1_valid) grant = ~last_served;
        else                          grant = req1_valid;
        req0_ready = !reset && req0_valid && !grant;
        req1_ready = !reset && req1_valid && grant;
        if (req0_ready || req1_ready) state_nxt = RUN;
      end
      RUN:     if (cnt == 2'd3) state_nxt = DONE;
      DONE:    if (res_ready)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = req0_ready || req1_ready;

  // One shift-add step: conditional add into the upper five bits, then shift.
  assign sum    = p_q[0] ? ({1'b0, p_q[7:4]} + {1'b0, a_q}) : p_q[8:4];
  assign p_step = {1'b0, sum, p_q[3:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= (RR_INIT == 0);
      a_q         <= 4'd0;
      p_q         <= 9'd0;
      cnt         <= 2'd0;
      id_q        <= 1'b0;
      res_data_q  <= 8'd0;
      res_id_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            last_served <= grant;
            id_q        <= grant;
            a_q         <= grant ? req1_a : req0_a;
            p_q         <= {5'd0, (grant ? req1_b : req0_b)};
            cnt         <= 2'd0;
          end
        end
        RUN: begin
          p_q <= p_step;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            res_data_q <= p_step[7:0];
            res_id_q   <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state == DONE);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed and randomized checks of mul_sched against a
// transaction-level model (arbitration rule, fixed latency, product a*b).
`default_nettype none

module tb_mul_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_a = 4'd0;
  logic [3:0] req0_b = 4'd0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_a = 4'd0;
  logic [3:0] req1_b = 4'd0;
  logic       req1_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_id;
  logic       res_ready = 1'b0;
  logic       busy;

  mul_sched #(.RR_INIT(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: phase 0 = idle, 1..4 = edges since accept, 5 = result held.
  int         m_phase = 0;
  bit         m_last = 1'b1;
  logic [7:0] m_prod = 8'd0;
  bit         m_cid = 1'b0;
  logic [7:0] m_data = 8'd0;
  bit         m_id = 1'b0;
  bit         started = 1'b0;
  int         cyc = 0;

  function automatic bit exp_rdy(input bit id);
    if (reset || m_phase != 0) return 1'b0;
    if (id == 1'b0) return req0_valid && (!req1_valid || m_last == 1'b1);
    return req1_valid && (!req0_valid || m_last == 1'b0);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_phase = 0; m_last = 1'b1; m_data = 8'd0; m_id = 1'b0; started = 1'b1;
    end else if (m_phase == 0) begin
      if (exp_rdy(1'b0)) begin
        m_prod = 8'(req0_a) * 8'(req0_b); m_cid = 1'b0; m_last = 1'b0; m_phase = 1;
      end else if (exp_rdy(1'b1)) begin
        m_prod = 8'(req1_a) * 8'(req1_b); m_cid = 1'b1; m_last = 1'b1; m_phase = 1;
      end
    end else if (m_phase < 5) begin
      m_phase++;
      if (m_phase == 5) begin
        m_data = m_prod; m_id = m_cid;
      end
    end else if (res_ready) begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("req0_ready", 32'(req0_ready), 32'(exp_rdy(1'b0)));
      chk("req1_ready", 32'(req1_ready), 32'(exp_rdy(1'b1)));
      chk("busy",       32'(busy),       32'(m_phase != 0));
      chk("res_valid",  32'(res_valid),  32'(m_phase == 5));
      chk("res_data",   32'(res_data),   32'(m_data));
      chk("res_id",     32'(res_id),     32'(m_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input logic [3:0] a, input logic [3:0] b);
    if (id == 1'b0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else            begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
  endtask

  task automatic await_accept(input bit id, output int at);
    bit got = 1'b0;
    at = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = (id == 1'b0) ? req0_ready : req1_ready;
      tick();
    end
    if (got) at = cyc;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk("accept_wait", 32'(got), 32'd1);
  endtask

  task automatic await_result(input logic [7:0] d, input bit id, input string nm);
    int n = 0;
    while (!res_valid && n < 40) begin tick(); n++; end
    chk("result_wait", 32'(res_valid), 32'd1);
    chk(nm, 32'(res_data), 32'(d));
    chk("result_id", 32'(res_id), 32'(id));
  endtask

  initial begin
    int t0, t1, lat;
    logic [3:0] oa [3];
    logic [3:0] ob [3];
    bit acc0, acc1;

    tick(); tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_res_valid", 32'(res_valid), 32'd0);
    chk("reset_res_data", 32'(res_data), 32'd0);
    reset = 1'b0;
    res_ready = 1'b1;

    // 15*15 with latency measured from the accept edge
    set_req(1'b0, 4'd15, 4'd15);
    await_accept(1'b0, t0);
    lat = 0;
    while (!res_valid && lat < 20) begin tick(); lat++; end
    chk("latency", 32'(lat), 32'd4);
    chk("mul_15x15", 32'(res_data), 32'hE1);
    chk("id_15x15", 32'(res_id), 32'd0);
    tick();
    chk("busy_after_drain", 32'(busy), 32'd0);

    // Contention right after reset: requester 0 first, then requester 1
    reset = 1'b1; tick(); reset = 1'b0;
    set_req(1'b0, 4'd3, 4'd5);
    set_req(1'b1, 4'd7, 4'd9);
    await_accept(1'b0, t0);
    await_result(8'h0F, 1'b0, "mul_3x5");
    await_accept(1'b1, t0);
    await_result(8'h3F, 1'b1, "mul_7x9");

    // Requester 1 alone, back to back, at the minimum issue interval
    for (int i = 0; i < 3; i++) begin oa[i] = 4'($urandom); ob[i] = 4'($urandom); end
    set_req(1'b1, oa[0], ob[0]);
    await_accept(1'b1, t0);
    for (int i = 1; i < 3; i++) begin
      set_req(1'b1, oa[i], ob[i]);
      await_result(8'(oa[i-1]) * 8'(ob[i-1]), 1'b1, "b2b_result");
      await_accept(1'b1, t1);
      chk("issue_interval", 32'(t1 - t0), 32'd6);
      t0 = t1;
    end
    await_result(8'(oa[2]) * 8'(ob[2]), 1'b1, "b2b_result");

    // Exhaustive operand sweep through requester 0
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        set_req(1'b0, 4'(a), 4'(b));
        await_accept(1'b0, t0);
        await_result(8'(a * b), 1'b0, "sweep");
      end
    end

    // Back-pressure in DONE: result holds, no requester is granted
    tick();
    res_ready = 1'b0;
    set_req(1'b0, 4'd9, 4'd11);
    await_accept(1'b0, t0);
    await_result(8'h63, 1'b0, "mul_9x11");
    set_req(1'b0, 4'd2, 4'd3);
    set_req(1'b1, 4'd4, 4'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", 32'(res_data), 32'h63);
      chk("hold_id", 32'(res_id), 32'd0);
      chk("hold_rdy0", 32'(req0_ready), 32'd0);
      chk("hold_rdy1", 32'(req1_ready), 32'd0);
    end
    res_ready = 1'b1;
    await_accept(1'b1, t0);
    await_result(8'h14, 1'b1, "mul_4x5");
    await_accept(1'b0, t0);
    await_result(8'h06, 1'b0, "mul_2x3");

    // Reset on the second RUN cycle discards the operation
    tick();
    set_req(1'b0, 4'd13, 4'd13);
    await_accept(1'b0, t0);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    set_req(1'b0, 4'd6, 4'd7);
    await_accept(1'b0, t0);
    await_result(8'h2A, 1'b0, "mul_6x7");

    // Randomized traffic, back-pressure, withdrawals and occasional resets
    acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid && ($urandom % 3) == 0) set_req(1'b0, 4'($urandom), 4'($urandom));
      else if (req0_valid && ($urandom % 40) == 0) req0_valid = 1'b0;
      if (!req1_valid && ($urandom % 3) == 0) set_req(1'b1, 4'($urandom), 4'($urandom));
      else if (req1_valid && ($urandom % 40) == 0) req1_valid = 1'b0;
      res_ready = ($urandom % 2) == 1;
      reset = ($urandom % 150) == 0;
      @(negedge clk);
      acc0 = req0_ready;
      acc1 = req1_ready;
      tick();
    end
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
